// File: rtl/note_voice.sv
// note_voice: enveloped, PWM-gated square-wave tone generator for the tune sequencer.
// Define NOTE_VOICE_DIFF_EN to add the complementary speaker_n output for differential piezo drive.
module note_voice #(
  parameter int ENV_DIV       = 4700,
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 2,
  parameter int SUSTAIN_LEVEL = 192,
  parameter int RELEASE_STEP  = 4
) (
  input  logic        clk12MHz,
  input  logic        resetn,
  input  logic [14:0] notetime,
  output logic        speaker,
`ifdef NOTE_VOICE_DIFF_EN
  output logic        speaker_n,
`endif
  output logic [7:0]  level,
  output logic        active
);
  localparam logic [2:0] IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4;
  localparam int DW = ENV_DIV > 1 ? $clog2(ENV_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(ENV_DIV - 1);
  localparam logic [8:0] A_STEP = 9'(ATTACK_STEP);
  localparam logic [8:0] D_STEP = 9'(DECAY_STEP);
  localparam logic [8:0] SUS_LVL = 9'(SUSTAIN_LEVEL);
  localparam logic [8:0] R_STEP = 9'(RELEASE_STEP);
  logic [14:0] s1_q, s2_q, req_q, prev_q, period_q, timer_q, timer_d;
  logic [2:0] state_q, state_d;
  logic [7:0] level_q, level_d, pwm_q;
  logic [DW-1:0] div_q;
  logic phase_q, phase_d, speaker_q;
  logic trig, tick, rest, on, pwm_on;
  logic [8:0] lvl9, up9, dec9, rel9;
  assign trig   = req_q != '0 && req_q != prev_q;
  assign tick   = div_q == DIV_MAX;
  assign on     = state_q != IDLE;
  assign rest   = req_q == '0 && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN);
  assign pwm_on = pwm_q < level_q;
  // 9-bit envelope arithmetic so saturation is decided before truncation
  assign lvl9 = {1'b0, level_q};
  assign up9  = lvl9 + A_STEP;
  assign dec9 = lvl9 >= SUS_LVL + D_STEP ? lvl9 - D_STEP : SUS_LVL;
  assign rel9 = lvl9 >= R_STEP ? lvl9 - R_STEP : '0;
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (trig) state_d = ATTACK;
    else if (rest) state_d = RELEASE;
    else if (tick) begin
      case (state_q)
        ATTACK: begin
          level_d = up9 > 9'd255 ? 8'hff : up9[7:0];
          state_d = up9 >= 9'd255 ? DECAY : ATTACK;
        end
        DECAY: begin
          level_d = dec9[7:0];
          state_d = dec9 == SUS_LVL ? SUSTAIN : DECAY;
        end
        RELEASE: begin
          level_d = rel9[7:0];
          state_d = rel9 == '0 ? IDLE : RELEASE;
        end
        IDLE:    level_d = '0;
        default: level_d = level_q;
      endcase
    end
  end
  always_comb begin
    timer_d = timer_q == period_q ? '0 : timer_q + 15'd1;
    phase_d = timer_q == period_q ? ~phase_q : phase_q;
    if (trig || state_d == IDLE) begin
      timer_d = '0;
      phase_d = 1'b0;
    end
  end
`ifdef NOTE_VOICE_DIFF_EN
  logic speaker_n_q;
  always_ff @(posedge clk12MHz)
    speaker_n_q <= resetn ? ~phase_q & pwm_on & on : 1'b0;
  assign speaker_n = speaker_n_q;
`endif
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      s1_q      <= '0;
      s2_q      <= '0;
      req_q     <= '0;
      prev_q    <= '0;
      period_q  <= '0;
      timer_q   <= '0;
      phase_q   <= 1'b0;
      state_q   <= IDLE;
      level_q   <= '0;
      div_q     <= '0;
      pwm_q     <= '0;
      speaker_q <= 1'b0;
    end else begin
      s1_q      <= notetime;
      s2_q      <= s1_q;
      req_q     <= s1_q == s2_q ? s2_q : req_q;
      prev_q    <= req_q;
      period_q  <= trig ? req_q : period_q;
      timer_q   <= timer_d;
      phase_q   <= phase_d;
      state_q   <= state_d;
      level_q   <= level_d;
      div_q     <= tick ? '0 : div_q + DW'(1);
      pwm_q     <= pwm_q + 8'd1;
      speaker_q <= phase_q & pwm_on & on;
    end
  end
  assign speaker = speaker_q;
  assign level   = level_q;
  assign active  = on;
endmodule

// File: tb/tb_note_voice.sv
// tb_note_voice: randomized bench for note_voice against an event-level envelope/tone model.
module tb_note_voice;
  localparam int ENV = 4;
  localparam int IDLE = 0, ATT = 1, DEC = 2, SUS = 3, REL = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [14:0] notetime = '0;
  logic speaker, active;
  logic [7:0] level;
`ifdef NOTE_VOICE_DIFF_EN
  logic speaker_n;
`endif
  note_voice #(.ENV_DIV(ENV)) dut (
    .clk12MHz(clk),
    .resetn(resetn),
    .notetime(notetime),
    .speaker(speaker),
`ifdef NOTE_VOICE_DIFF_EN
    .speaker_n(speaker_n),
`endif
    .level(level),
    .active(active)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int s1, s2, req, prev, st, lvl, per, n, dv, pwm, spk, spkn;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask
  // tone phase follows from cycles elapsed since the note was triggered
  function automatic int ph();
    return st != IDLE ? (n / (per + 1)) % 2 : 0;
  endfunction
  task automatic model_step();
    int nt;
    bit trig, tick;
    nt = int'(notetime);
    if (!resetn) begin
      s1 = 0; s2 = 0; req = 0; prev = 0; st = IDLE; lvl = 0; per = 0;
      n = 0; dv = 0; pwm = 0; spk = 0; spkn = 0;
      return;
    end
    trig = req != 0 && req != prev;
    tick = dv == ENV - 1;
    spk  = (ph() == 1 && pwm < lvl && st != IDLE) ? 1 : 0;
    spkn = (ph() == 0 && pwm < lvl && st != IDLE) ? 1 : 0;
    if (trig) begin
      st = ATT; per = req; n = 0;
    end else begin
      if (st != IDLE) n++;
      if (req == 0 && st inside {ATT, DEC, SUS}) st = REL;
      else if (tick) begin
        if (st == ATT) begin
          lvl = (lvl + 8 > 255) ? 255 : lvl + 8;
          if (lvl == 255) st = DEC;
        end else if (st == DEC) begin
          lvl = (lvl - 2 < 192) ? 192 : lvl - 2;
          if (lvl == 192) st = SUS;
        end else if (st == REL) begin
          lvl = (lvl - 4 < 0) ? 0 : lvl - 4;
          if (lvl == 0) st = IDLE;
        end else if (st == IDLE) lvl = 0;
      end
      if (st == IDLE) n = 0;
    end
    dv   = tick ? 0 : dv + 1;
    pwm  = (pwm + 1) % 256;
    prev = req;
    if (s1 == s2) req = s2;
    s2 = s1;
    s1 = nt;
  endtask
  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      model_step();
      #1;
      chk("level", level, lvl);
      chk("active", active, st != IDLE);
      chk("speaker", speaker, spk);
`ifdef NOTE_VOICE_DIFF_EN
      chk("speaker_n", speaker_n, spkn);
      chk("diff_excl", speaker & speaker_n, 0);
`endif
    end
  endtask
  initial begin
    resetn = 1'b0;
    notetime = 15'd1000;
    cyc(5);
    chk("rst_level", level, 0);
    chk("rst_active", active, 0);
    chk("rst_speaker", speaker, 0);
    resetn = 1'b1;
    cyc(3);
    chk("req_c3_not_yet_active", active, 0);
    cyc(1);
    chk("trig_c4_active", active, 1);
    notetime = 15'd100;
    cyc(700);
    chk("sustain_level", level, 192);
    while (dv != 0) cyc(1);
    notetime = 15'd200;
    cyc(4);
    chk("tie_level", level, 192);
    cyc(4);
    chk("retrig_from_sustain", level, 200);
    cyc(400);
    notetime = 15'd0;
    cyc(48 * ENV + 12);
    chk("release_idle_active", active, 0);
    chk("release_idle_level", level, 0);
    chk("release_idle_speaker", speaker, 0);
    notetime = 15'd100;
    cyc(300);
    notetime = 15'd37;
    cyc(1);
    notetime = 15'd100;
    cyc(20);
    chk("glitch_no_retrig", level, 192);
    notetime = 15'd0;
    cyc(2);
    notetime = 15'd100;
    cyc(200);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: notetime = 15'($urandom_range(1, 400));
        1: notetime = 15'd0;
        2: begin
          notetime = 15'($urandom_range(0, 32767));
          cyc(1);
          notetime = 15'($urandom_range(1, 300));
        end
        3: begin
          resetn = 1'b0;
          cyc($urandom_range(1, 3));
          resetn = 1'b1;
        end
        default: begin
          notetime = 15'd0;
          cyc($urandom_range(1, 3));
          notetime = 15'($urandom_range(1, 300));
        end
      endcase
      cyc($urandom_range(1, 300));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
